// File: rtl/lut_sweeper.sv
// Run-time programmable N-input truth table with registered lookup, serial
// MSB-first reprogramming and a sweep engine that lists every entry and counts the ones.
module lut_sweeper #(
  parameter int N = 4,
  parameter logic [(1<<N)-1:0] INIT = 16'h0AC5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  output logic         y,
  input  logic         load_en,
  input  logic         load_bit,
  output logic         load_done,
  input  logic         sweep_start,
  output logic         sweep_busy,
  output logic         sweep_valid,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_y,
  output logic         sweep_done,
  output logic [N:0]   ones_cnt
);

  localparam int W = 1 << N;
  localparam logic [N:0] LAST_BIT = (N+1)'(W - 1);
  localparam logic [N-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   table_q, table_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [N:0]     cnt_q, cnt_d;
  logic [N-1:0]   k_q, k_d;
  logic [N:0]     ones_q, ones_d;
  logic           y_q, y_d;
  logic           load_done_q, load_done_d;

  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    ones_d      = ones_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A load request takes priority; a simultaneous sweep request is dropped.
        if (load_en) begin
          shadow_d = {shadow_q[W-2:0], load_bit};
          cnt_d    = {{N{1'b0}}, 1'b1};
          state_d  = LOAD;
        end else if (sweep_start) begin
          k_d     = '0;
          ones_d  = '0;
          state_d = SWEEP;
        end
      end
      LOAD: begin
        if (load_en) begin
          shadow_d = {shadow_q[W-2:0], load_bit};
          if (cnt_q == LAST_BIT) begin
            table_d     = shadow_d;
            load_done_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      SWEEP: begin
        ones_d = ones_q + {{N{1'b0}}, table_q[k_q]};
        if (k_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The lookup sees a table committed at this same edge.
    y_d = table_d[x];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      table_q     <= INIT;
      shadow_q    <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      ones_q      <= '0;
      y_q         <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      ones_q      <= ones_d;
      y_q         <= y_d;
      load_done_q <= load_done_d;
    end
  end

  assign y           = y_q;
  assign load_done   = load_done_q;
  assign sweep_valid = (state_q == SWEEP);
  assign sweep_busy  = (state_q == SWEEP) || (state_q == DONE);
  assign sweep_done  = (state_q == DONE);
  assign sweep_idx   = sweep_valid ? k_q : '0;
  assign sweep_y     = sweep_valid & table_q[k_q];
  assign ones_cnt    = ones_q;

endmodule

// File: tb/tb_lut_sweeper.sv
// Self-checking bench for lut_sweeper: randomized evaluation, loads and sweeps
// checked against a plain truth-table model, plus a small N=2 instance.
module tb_lut_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] x;
  logic       y, load_en, load_bit, load_done, sweep_start;
  logic       sweep_busy, sweep_valid, sweep_y, sweep_done;
  logic [3:0] sweep_idx;
  logic [4:0] ones_cnt;

  logic [1:0] x2;
  logic       y2, load_en2, load_bit2, load_done2, sweep_start2;
  logic       sweep_busy2, sweep_valid2, sweep_y2, sweep_done2;
  logic [1:0] sweep_idx2;
  logic [2:0] ones_cnt2;

  localparam bit [15:0] INIT_TBL = 16'h0AC5;
  bit [15:0] model;
  int n_checks = 0;
  int n_fail = 0;

  lut_sweeper u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .load_en(load_en), .load_bit(load_bit), .load_done(load_done),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_valid(sweep_valid),
    .sweep_idx(sweep_idx), .sweep_y(sweep_y), .sweep_done(sweep_done), .ones_cnt(ones_cnt)
  );

  lut_sweeper #(.N(2), .INIT(4'b1000)) u_dut2 (
    .clk(clk), .rst(rst), .x(x2), .y(y2),
    .load_en(load_en2), .load_bit(load_bit2), .load_done(load_done2),
    .sweep_start(sweep_start2), .sweep_busy(sweep_busy2), .sweep_valid(sweep_valid2),
    .sweep_idx(sweep_idx2), .sweep_y(sweep_y2), .sweep_done(sweep_done2), .ones_cnt(ones_cnt2)
  );

  // The two done pulses must never coincide.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (load_done && sweep_done) begin
        n_fail++;
        $display("FAIL done_overlap: load_done=%0b sweep_done=%0b required not both 1", load_done, sweep_done);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; x = '0; load_en = 0; load_bit = 0; sweep_start = 0;
    x2 = '0; load_en2 = 0; load_bit2 = 0; sweep_start2 = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({y, load_done, sweep_busy, sweep_valid, sweep_idx, sweep_y, sweep_done, ones_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got y=%0b ld=%0b busy=%0b v=%0b idx=%0d sy=%0b sd=%0b ones=%0d required all 0",
               y, load_done, sweep_busy, sweep_valid, sweep_idx, sweep_y, sweep_done, ones_cnt);
    end
    rst = 1'b0;
    model = INIT_TBL;
    @(negedge clk);
    $display("reset: table restored to %h", model);
  endtask

  task automatic test_eval(input int n_rand);
    logic [3:0] prev;
    prev = 4'd0;
    x = prev;
    for (int i = 1; i <= 16 + n_rand; i++) begin
      @(negedge clk);
      n_checks++;
      if (y !== model[prev]) begin
        n_fail++;
        $display("FAIL eval_y: x=%0d got y=%0b required %0b", prev, y, model[prev]);
      end
      prev = (i < 16) ? 4'(i) : 4'($urandom);
      x = prev;
    end
    @(negedge clk);
    $display("eval: %0d lookups against table %h", 16 + n_rand, model);
  endtask

  task automatic test_sweep();
    int exp_ones;
    exp_ones = $countones(model);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if ({sweep_valid, sweep_busy, sweep_done, sweep_idx, sweep_y} !== {3'b110, 4'(k), model[k]}) begin
        n_fail++;
        $display("FAIL sweep_beat: k=%0d got v=%0b busy=%0b sd=%0b idx=%0d sy=%0b required v=1 busy=1 sd=0 idx=%0d sy=%0b",
                 k, sweep_valid, sweep_busy, sweep_done, sweep_idx, sweep_y, k, model[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({sweep_done, sweep_busy, sweep_valid} !== 3'b110 || ones_cnt !== 5'(exp_ones)) begin
      n_fail++;
      $display("FAIL sweep_done: got sd=%0b busy=%0b v=%0b ones=%0d required sd=1 busy=1 v=0 ones=%0d",
               sweep_done, sweep_busy, sweep_valid, ones_cnt, exp_ones);
    end
    @(negedge clk);
    n_checks++;
    if ({sweep_done, sweep_busy} !== 2'b00 || ones_cnt !== 5'(exp_ones)) begin
      n_fail++;
      $display("FAIL sweep_idle: got sd=%0b busy=%0b ones=%0d required sd=0 busy=0 ones=%0d",
               sweep_done, sweep_busy, ones_cnt, exp_ones);
    end
    $display("sweep: table %h ones_cnt=%0d", model, ones_cnt);
  endtask

  task automatic test_load(input logic [15:0] vec, input int nbits, input bit with_start);
    for (int i = 0; i < nbits; i++) begin
      load_en = 1'b1;
      load_bit = vec[15-i];
      sweep_start = with_start && (i == 0);
      @(negedge clk);
      sweep_start = 1'b0;
      n_checks++;
      if (load_done !== (i == 15) || sweep_valid !== 1'b0 || sweep_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL load_bit%0d: got ld=%0b v=%0b busy=%0b required ld=%0b v=0 busy=0",
                 i, load_done, sweep_valid, sweep_busy, (i == 15));
      end
    end
    load_en = 1'b0;
    if (nbits == 16) model = vec;
    @(negedge clk);
    n_checks++;
    if (load_done !== 1'b0 || sweep_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_after: got ld=%0b busy=%0b required ld=0 busy=0", load_done, sweep_busy);
    end
    $display("load: vec=%h bits=%0d start=%0b table now %h", vec, nbits, with_start, model);
  endtask

  task automatic test_reset_mid_sweep();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sweep_idx !== 4'd5 || sweep_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sweep_idx: got idx=%0d v=%0b required idx=5 v=1", sweep_idx, sweep_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({y, load_done, sweep_busy, sweep_valid, sweep_idx, sweep_y, sweep_done, ones_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: got busy=%0b v=%0b idx=%0d sy=%0b sd=%0b ones=%0d y=%0b required all 0",
               sweep_busy, sweep_valid, sweep_idx, sweep_y, sweep_done, ones_cnt, y);
    end
    @(negedge clk);
    rst = 1'b0;
    model = INIT_TBL;
    @(negedge clk);
    $display("reset mid-sweep at beat 5");
  endtask

  task automatic test_small_n();
    sweep_start2 = 1'b1;
    @(negedge clk);
    sweep_start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({sweep_valid2, sweep_done2, sweep_idx2, sweep_y2} !== {2'b10, 2'(k), (k == 3)}) begin
        n_fail++;
        $display("FAIL n2_beat: k=%0d got v=%0b sd=%0b idx=%0d sy=%0b required v=1 sd=0 idx=%0d sy=%0b",
                 k, sweep_valid2, sweep_done2, sweep_idx2, sweep_y2, k, (k == 3));
      end
      @(negedge clk);
    end
    n_checks++;
    if (sweep_done2 !== 1'b1 || ones_cnt2 !== 3'd1) begin
      n_fail++;
      $display("FAIL n2_done: got sd=%0b ones=%0d required sd=1 ones=1", sweep_done2, ones_cnt2);
    end
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      x2 = 2'(v);
      @(negedge clk);
      n_checks++;
      if (y2 !== (v == 3)) begin
        n_fail++;
        $display("FAIL n2_eval: x=%0d got y=%0b required %0b", v, y2, (v == 3));
      end
    end
    $display("small N=2 sweep ones_cnt=%0d", ones_cnt2);
  endtask

  initial begin
    test_reset();
    test_eval(20);
    test_sweep();
    test_load(16'hFFFF, 16, 1'b0);
    test_sweep();
    test_load(16'h0001, 16, 1'b0);
    test_eval(20);
    test_reset();
    test_load(16'(($urandom)), 8, 1'b0);
    test_sweep();
    test_load(16'(($urandom)), 16, 1'b1);
    test_eval(16);
    test_sweep();
    test_reset_mid_sweep();
    test_sweep();
    test_small_n();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
